register_file_p: RTL
====================

REGISTER_FILE_P -- requirements
Module: register_file_p

Interface
REQ-001 Parameter WIDTH, default 8: bit width of each register and of every data port.
REQ-002 Parameter AW, default 3: address width; register count DEPTH = 2**AW (default 8).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 we  input  1  write enable; high = write wData into register wAddr at next rising clk.
REQ-006 wAddr  input  AW  write address.
REQ-007 wData  input  WIDTH  write data.
REQ-008 clr  input  1  synchronous clear-all request.
REQ-009 rAddr0  input  AW  read port 0 address.
REQ-010 rAddr1  input  AW  read port 1 address.
REQ-011 rData0  output  WIDTH  read port 0 data.
REQ-012 rData1  output  WIDTH  read port 1 data.
REQ-013 wr_cnt  output  8  count of completed writes since reset or clear, saturating.

Function
REQ-014 Storage: DEPTH registers, each WIDTH bits, built as an array of D flip-flop registers with async active-low reset.
REQ-015 Write: on a rising clk with we=1 and clr=0, register[wAddr] takes wData; all other registers hold.
REQ-016 Hold: on a rising clk with we=0 and clr=0, every register holds its value.
REQ-017 Clear: on a rising clk with clr=1, every register becomes 0 and wr_cnt becomes 0; a simultaneous we is ignored (clr has priority).
REQ-018 Read: rData0 = register[rAddr0] and rData1 = register[rAddr1], combinational, no clock latency.
REQ-019 Both read ports may address the same register, including the one being written, with no conflict.
REQ-020 Write-to-read latency without bypass: data written at edge N is visible on rData after edge N (same cycle as the register update).
REQ-021 wr_cnt increments by 1 on each rising clk with we=1 and clr=0; at 255 it holds at 255 (no wrap).
REQ-022 All address values 0..DEPTH-1 are valid; no out-of-range case exists since DEPTH = 2**AW.
REQ-023 Inputs that are X while we=0 and clr=0 do not alter state.

Reset
REQ-024 reset_n=0 immediately, independent of clk, forces every register to 0 and wr_cnt to 0.
REQ-025 While reset_n=0, rData0=rData1=0 for all read addresses; we and clr are ignored.
REQ-026 Reset asserted mid-operation (including in the same cycle as a write) discards the write; after release, first rising clk with we=1 writes normally.

Configuration
REQ-027 Macro REGFILE_BYPASS_EN compiles in write-through forwarding.
REQ-028 With REGFILE_BYPASS_EN defined: when we=1, clr=0, reset_n=1 and rAddrX equals wAddr, rDataX presents wData combinationally in the same cycle before the clock edge.
REQ-029 With REGFILE_BYPASS_EN defined: when clr=1, rData0 and rData1 still show stored contents until the edge (clr is not forwarded).
REQ-030 Without REGFILE_BYPASS_EN: rDataX always shows stored register contents only (REQ-018); no forwarding logic is present.

Verification
REQ-031 Reset: reset_n=0 at t=0, drive rAddr0=0..7 -> rData0=0 and wr_cnt=0 throughout; release reset_n -> values unchanged.
REQ-032 Write/read: write 8'hA5 to reg 3 and 8'h5A to reg 6 on successive edges; rAddr0=3, rAddr1=6 -> rData0=8'hA5, rData1=8'h5A; wr_cnt=2; other registers remain 0.
REQ-033 Clear priority: with regs loaded, assert clr=1 and we=1 (wAddr=2, wData=8'hFF) for one edge -> all registers 0, reg 2 = 0, wr_cnt=0.
REQ-034 Bypass: reg 4 holds 8'h11; set we=1, wAddr=4, wData=8'h22, rAddr0=4 before edge -> rData0=8'h22 with REGFILE_BYPASS_EN, 8'h11 without; after edge both builds show 8'h22.
REQ-035 Async reset mid-write: assert reset_n=0 between clock edges while we=1, wData=8'h77 -> rData immediately 0, no write lands; wr_cnt=0.
REQ-036 Saturation: 300 consecutive writes with we=1 -> wr_cnt reaches 255 and holds at 255.

Source files
------------

// File: rtl/register_file_p.sv
// Multi-port register file with a saturating write counter.
// Define REGFILE_BYPASS_EN to forward write data to matching read ports.
module register_file_p #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we,
    input  logic [AW-1:0]    wAddr,
    input  logic [WIDTH-1:0] wData,
    input  logic             clr,
    input  logic [AW-1:0]    rAddr0,
    input  logic [AW-1:0]    rAddr1,
    output logic [WIDTH-1:0] rData0,
    output logic [WIDTH-1:0] rData1,
    output logic [7:0]       wr_cnt
);

    localparam int DEPTH = 2 ** AW;

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [7:0]       cnt_q;
    logic [7:0]       cnt_d;
    logic             wr_en;

    assign wr_en = we && !clr;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        cnt_d = cnt_q;
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_d[i] = '0;
            end
            cnt_d = '0;
        end else if (we) begin
            regs_d[wAddr] = wData;
            if (cnt_q != 8'hFF) begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        rData0 = regs_q[rAddr0];
        rData1 = regs_q[rAddr1];
`ifdef REGFILE_BYPASS_EN
        // clr is never forwarded; stored contents stay visible until the edge
        if (reset_n && wr_en && rAddr0 == wAddr) begin
            rData0 = wData;
        end
        if (reset_n && wr_en && rAddr1 == wAddr) begin
            rData1 = wData;
        end
`endif
    end

    assign wr_cnt = cnt_q;

endmodule
